pellet_store_controller: RTL

Owns the tile-granular pellet bitmap and sequences every access to it. The bitmap sits in one single-port RAM, and three clients share it: the VGA renderer (per-pixel reads), the Pac-Man eat path (read-modify-write, feeding the score logic) and the refill sequencer (sweeps the maze at game start). The block also tracks the remaining-pellet count and flags when the board is cleared. It sits between the position/VGA timing logic and the scoring FSM.

---
 rtl/pacman_pkg.sv | 26 ++
 rtl/pellet_bitmap_ram.sv | 22 ++
 rtl/pellet_store_controller.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pacman_pkg.sv
// Shared maze geometry, pellet controller state encoding and the tile-address helper.
package pacman_pkg;
  localparam int COLS       = 40;
  localparam int ROWS       = 30;
  localparam int TILE_SHIFT = 4;
  localparam int ADDR_W     = 11;
  localparam int NTILES     = COLS * ROWS;

  typedef enum logic [2:0] {IDLE, REFILL, RUN, EAT_RD, EAT_WR} pellet_ctl_state_t;

  typedef struct packed {
    logic              ok;
    logic [ADDR_W-1:0] addr;
  } tile_t;

  // Pixel coordinate to tile address; ok=0 when the tile lies outside the maze.
  function automatic tile_t tile_addr(input logic [9:0] x, input logic [9:0] y);
    tile_t             t;
    logic [ADDR_W-1:0] tx, ty;
    tx     = ADDR_W'(x >> TILE_SHIFT);
    ty     = ADDR_W'(y >> TILE_SHIFT);
    t.ok   = (tx < ADDR_W'(COLS)) && (ty < ADDR_W'(ROWS));
    t.addr = ty * ADDR_W'(COLS) + tx;
    return t;
  endfunction
endpackage

// File: rtl/pellet_bitmap_ram.sv
// Single-port 1-bit pellet bitmap, synchronous read (1-cycle latency); q holds on writes/idle.
module pellet_bitmap_ram
  import pacman_pkg::*;
#(
  parameter int DEPTH = NTILES
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wdata,
  output logic              q
);
  logic mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    q         <= mem[addr];
    end
  end
endmodule

// File: rtl/pellet_store_controller.sv
// Arbitrates the pellet bitmap between render reads, eat read-modify-writes and the refill sweep.
module pellet_store_controller
  import pacman_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [9:0]        hCount,
  input  logic [9:0]        vCount,
  input  logic              rd_req,
  output logic              rd_data,
  input  logic [9:0]        pacX,
  input  logic [9:0]        pacY,
  input  logic              eat_req,
  output logic              eat_ack,
  output logic              eat_hit,
  output logic [ADDR_W-1:0] init_addr,
  input  logic              init_bit,
  output logic [ADDR_W-1:0] remaining,
  output logic              all_eaten,
  output logic              refill_done
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NTILES - 1);

  pellet_ctl_state_t state, nstate;
  tile_t             rt, et;
  logic [ADDR_W-1:0] eat_addr_q, ram_addr;
  logic              eat_ok_q, wr_first_q, eat_bit_q, rd_srv_q, idle_ack_q;
  logic              ram_en, ram_we, ram_wd, ram_q, rd_srv, cur_bit, game;

  assign rt      = tile_addr(hCount, vCount);
  assign et      = tile_addr(pacX, pacY);
  assign game    = (state == RUN) || (state == EAT_RD) || (state == EAT_WR);
  assign rd_data = rd_srv_q & ram_q;
  // The eat read result is only on ram_q for the first EAT_WR cycle; render reads may overwrite it.
  assign cur_bit = wr_first_q ? (ram_q & eat_ok_q) : eat_bit_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (start) nstate = REFILL;
    else begin
      unique case (state)
        IDLE:    nstate = IDLE;
        REFILL:  if (init_addr == LAST) nstate = RUN;
        RUN:     if (eat_req && !rd_req) nstate = EAT_RD;
        EAT_RD:  if (!rd_req) nstate = EAT_WR;
        EAT_WR:  if (!cur_bit || !rd_req) nstate = RUN;
        default: nstate = IDLE;
      endcase
    end
  end

  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = rt.addr;
    ram_wd   = 1'b0;
    rd_srv   = 1'b0;
    eat_ack  = idle_ack_q && (state == IDLE);
    eat_hit  = 1'b0;
    if (game && rd_req) begin
      rd_srv = rt.ok;
      ram_en = rt.ok;
    end
    unique case (state)
      REFILL: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = init_addr;
        ram_wd   = init_bit;
      end
      EAT_RD: if (!rd_req && !start) begin
        ram_en   = eat_ok_q;
        ram_addr = eat_addr_q;
      end
      EAT_WR: if (!start) begin
        if (!cur_bit) eat_ack = 1'b1;
        else if (!rd_req) begin
          ram_en   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = eat_addr_q;
          eat_ack  = 1'b1;
          eat_hit  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      init_addr   <= '0;
      remaining   <= '0;
      all_eaten   <= 1'b0;
      refill_done <= 1'b0;
      eat_addr_q  <= '0;
      eat_ok_q    <= 1'b0;
      wr_first_q  <= 1'b0;
      eat_bit_q   <= 1'b0;
      rd_srv_q    <= 1'b0;
      idle_ack_q  <= 1'b0;
    end else begin
      rd_srv_q    <= rd_srv;
      idle_ack_q  <= (state == IDLE) && eat_req && !idle_ack_q && !start;
      refill_done <= (state == REFILL) && !start && (init_addr == LAST);
      all_eaten   <= game && (remaining == '0) && !start;
      wr_first_q  <= (state == EAT_RD) && (nstate == EAT_WR);
      if (state == EAT_WR) eat_bit_q <= cur_bit;
      if (state == RUN && eat_req && !rd_req) begin
        eat_addr_q <= et.addr;
        eat_ok_q   <= et.ok;
      end
      // A start anywhere restarts the sweep, so the count never includes a partial pass.
      if (start) begin
        init_addr <= '0;
        remaining <= '0;
      end else if (state == REFILL) begin
        init_addr <= (init_addr == LAST) ? '0 : init_addr + 1'b1;
        remaining <= remaining + ADDR_W'(init_bit);
      end else if (eat_hit) begin
        remaining <= remaining - 1'b1;
      end
    end
  end

  pellet_bitmap_ram u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wd),
    .q     (ram_q)
  );
endmodule
